// File: rtl/min_sec_counter.sv
// rtl/min_sec_counter.sv - seconds/minutes stage of the digital clock, 00:00..59:59 with hour carry
// Optional build macro: BLINK_EN (2 Hz blanking of the minute digits while in SET).
module min_sec_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic       clock,
  input  logic       ZERA,
  input  logic       SW17,
  input  logic       KEY_MIN,
  output logic       tick_h,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic [6:0] hex_su,
  output logic [6:0] hex_st,
  output logic [6:0] hex_mu,
  output logic [6:0] hex_mt
);

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [6:0]       SEG_ZERO  = 7'h40;

  state_t           state;
  logic [DIV_W-1:0] presc;
  logic             sec_tick;

  logic             key_meta;
  logic             key_sync;
  logic             key_prev;
  logic             key_rise;

  logic             enter_set;
  logic             hold_presc;
  logic             blank_min;

  // Digit wrap flags; >= keeps a corrupted digit from running past its range.
  logic             su_wrap;
  logic             st_wrap;
  logic             mu_wrap;
  logic             mt_wrap;
  logic             top_of_hour;

  // Segment decode {g,f,e,d,c,b,a}, active-low; anything outside 0-9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign sec_tick    = (presc == DIV_LAST);
  assign key_rise    = key_sync & ~key_prev;
  assign enter_set   = (state == RUN) && SW17;
  // Prescaler is held in SET and cleared on SET entry, so RUN restarts with a full second.
  assign hold_presc  = (state == SET) || SW17;

  assign su_wrap     = (sec_u >= 4'd9);
  assign st_wrap     = (sec_t >= 3'd5);
  assign mu_wrap     = (min_u >= 4'd9);
  assign mt_wrap     = (min_t >= 3'd5);
  assign top_of_hour = su_wrap && st_wrap && mu_wrap && mt_wrap;

  // Prescaler: 0..TICK_DIV-1, sec_tick on the last count.
  always_ff @(posedge clock or posedge ZERA) begin
    if (ZERA) begin
      presc <= '0;
    end else if (hold_presc || sec_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  // Two-flop synchronizer plus one history flop for KEY_MIN rising-edge detection.
  always_ff @(posedge clock or posedge ZERA) begin
    if (ZERA) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= KEY_MIN;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  // RUN/SET state machine with the BCD counters and the registered hour carry.
  always_ff @(posedge clock or posedge ZERA) begin
    if (ZERA) begin
      state  <= RUN;
      sec_u  <= 4'd0;
      sec_t  <= 3'd0;
      min_u  <= 4'd0;
      min_t  <= 3'd0;
      tick_h <= 1'b0;
    end else begin
      tick_h <= 1'b0;
      case (state)
        RUN: begin
          if (SW17) begin
            // A tick landing on this edge is dropped; seconds restart from 00.
            state <= SET;
            sec_u <= 4'd0;
            sec_t <= 3'd0;
          end else if (sec_tick) begin
            if (su_wrap) begin
              sec_u <= 4'd0;
              if (st_wrap) begin
                sec_t <= 3'd0;
                if (mu_wrap) begin
                  min_u <= 4'd0;
                  min_t <= mt_wrap ? 3'd0 : min_t + 3'd1;
                end else begin
                  min_u <= min_u + 4'd1;
                end
              end else begin
                sec_t <= sec_t + 3'd1;
              end
            end else begin
              sec_u <= sec_u + 4'd1;
            end
            tick_h <= top_of_hour;
          end
        end
        SET: begin
          if (!SW17) begin
            // Leaving SET takes priority over a key edge on the same cycle.
            state <= RUN;
          end else if (key_rise) begin
            // Manual minute wrap never produces an hour carry.
            if (mu_wrap) begin
              min_u <= 4'd0;
              min_t <= mt_wrap ? 3'd0 : min_t + 3'd1;
            end else begin
              min_u <= min_u + 4'd1;
            end
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int               BLINK_DIV  = (TICK_DIV / 4 < 1) ? 1 : TICK_DIV / 4;
  localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] blink_cnt;
  logic             blink_phase;

  // Blink timebase: phase toggles every BLINK_DIV clocks, restarted on SET entry.
  always_ff @(posedge clock or posedge ZERA) begin
    if (ZERA) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (enter_set) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + DIV_W'(1);
    end
  end

  assign blank_min = (state == SET) && blink_phase;
`else
  logic unused_enter_set;
  assign unused_enter_set = enter_set;
  assign blank_min        = 1'b0;
`endif

  // Registered segment drivers, one cycle behind the digits.
  always_ff @(posedge clock or posedge ZERA) begin
    if (ZERA) begin
      hex_su <= SEG_ZERO;
      hex_st <= SEG_ZERO;
      hex_mu <= SEG_ZERO;
      hex_mt <= SEG_ZERO;
    end else begin
      hex_su <= seg7(sec_u);
      hex_st <= seg7({1'b0, sec_t});
      hex_mu <= blank_min ? SEG_BLANK : seg7(min_u);
      hex_mt <= blank_min ? SEG_BLANK : seg7({1'b0, min_t});
    end
  end

endmodule

// File: tb/tb_min_sec_counter.sv
// tb/tb_min_sec_counter.sv - directed and random bench for min_sec_counter against a seconds-of-hour model
module tb_min_sec_counter;

  localparam int TD = 4;
  localparam int BD = (TD / 4 < 1) ? 1 : TD / 4;

  logic       clock = 1'b0;
  logic       ZERA = 1'b1;
  logic       SW17 = 1'b0;
  logic       KEY_MIN = 1'b0;
  logic       tick_h;
  logic [3:0] sec_u;
  logic [2:0] sec_t;
  logic [3:0] min_u;
  logic [2:0] min_t;
  logic [6:0] hex_su, hex_st, hex_mu, hex_mt;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;

  min_sec_counter #(.TICK_DIV(TD), .DIV_W(26)) dut (
    .clock(clock), .ZERA(ZERA), .SW17(SW17), .KEY_MIN(KEY_MIN),
    .tick_h(tick_h), .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
    .hex_su(hex_su), .hex_st(hex_st), .hex_mu(hex_mu), .hex_mt(hex_mt)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: time as seconds into the hour, plus mode and key history.
  int         m_secs;
  bit         m_set;
  int         m_pre;
  bit         m_k1, m_k2, m_k3;
  bit         m_tick;
  int         m_bcnt;
  bit         m_phase;
  logic [6:0] e_su, e_st, e_mu, e_mt;

  function automatic logic [13:0] pack_time(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_set = 0; m_pre = 0;
    m_k1 = 0; m_k2 = 0; m_k3 = 0;
    m_tick = 0; m_bcnt = 0; m_phase = 0;
    e_su = 7'h40; e_st = 7'h40; e_mu = 7'h40; e_mt = 7'h40;
  endtask

  task automatic model_edge();
    int  s_prev;
    bit  set_prev, ph_prev, ticking, rise, blank;
    s_prev   = m_secs;
    set_prev = m_set;
    ph_prev  = m_phase;
    ticking  = !m_set && (m_pre == TD - 1);
    rise     = m_k2 && !m_k3;
`ifdef BLINK_EN
    blank = set_prev && ph_prev;
`else
    blank = 1'b0;
`endif
    e_su = seg_tab[(s_prev % 60) % 10];
    e_st = seg_tab[(s_prev % 60) / 10];
    e_mu = blank ? 7'h7F : seg_tab[(s_prev / 60) % 10];
    e_mt = blank ? 7'h7F : seg_tab[(s_prev / 60) / 10];
    m_tick = 0;
    if (!m_set) begin
      if (SW17) begin
        m_set  = 1;
        m_secs = m_secs - (m_secs % 60);
        m_pre  = 0;
      end else if (ticking) begin
        m_pre = 0;
        if (m_secs == 3599) begin
          m_secs = 0;
          m_tick = 1;
        end else begin
          m_secs = m_secs + 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end else begin
      m_pre = 0;
      if (!SW17) m_set = 0;
      else if (rise) m_secs = ((m_secs / 60 + 1) % 60) * 60;
    end
    if (!set_prev && SW17) begin
      m_bcnt = 0; m_phase = 0;
    end else if (m_bcnt == BD - 1) begin
      m_bcnt = 0; m_phase = !m_phase;
    end else begin
      m_bcnt = m_bcnt + 1;
    end
    m_k3 = m_k2; m_k2 = m_k1; m_k1 = KEY_MIN;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    if (tick_h) tick_cnt++;
    chk("time", 32'({min_t, min_u, sec_t, sec_u}), 32'(pack_time(m_secs)));
    chk("tick_h", 32'(tick_h), 32'(m_tick));
    chk("hex_su", 32'(hex_su), 32'(e_su));
    chk("hex_st", 32'(hex_st), 32'(e_st));
    chk("hex_mu", 32'(hex_mu), 32'(e_mu));
    chk("hex_mt", 32'(hex_mt), 32'(e_mt));
  endtask

  task automatic key_press(input int len);
    KEY_MIN = 1'b1;
    repeat (len) step();
    KEY_MIN = 1'b0;
    repeat (3) step();
  endtask

  task automatic sync_reset();
    ZERA = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    ZERA = 1'b0;
  endtask

  initial begin
    int presses;
    int mins;
    logic [6:0] last_mt;

    model_reset();
    @(posedge clock);
    #1;
    ZERA = 1'b0;
    chk("init_time", 32'({min_t, min_u, sec_t, sec_u}), 32'(0));
    chk("init_hex", 32'({hex_su, hex_st, hex_mu, hex_mt}), 32'({4{7'h40}}));

    // 1. mid-cycle asynchronous reset, then first tick after 4 clocks
    repeat ($urandom_range(5, 12)) step();
    #2 ZERA = 1'b1;
    #1;
    model_reset();
    chk("async_rst_time", 32'({min_t, min_u, sec_t, sec_u}), 32'(0));
    chk("async_rst_tick", 32'(tick_h), 32'(0));
    chk("async_rst_hex", 32'({hex_su, hex_st, hex_mu, hex_mt}), 32'({4{7'h40}}));
    @(posedge clock);
    #1;
    ZERA = 1'b0;
    tick_cnt = 0;
    repeat (4) step();
    chk("sec_u_after_4", 32'(sec_u), 32'(1));

    // 2. seconds rollover to 01:00 with no hour carry
    repeat (236) step();
    chk("one_minute", 32'({min_t, min_u, sec_t, sec_u}), 32'(pack_time(60)));
    chk("no_carry_1min", 32'(tick_cnt), 32'(0));

    // 3. set mode at 00:37
    sync_reset();
    repeat (37 * TD) step();
    chk("at_0037", 32'({min_t, min_u, sec_t, sec_u}), 32'(pack_time(37)));
    SW17 = 1'b1;
    step();
    chk("set_clears_sec", 32'({sec_t, sec_u}), 32'(0));
    repeat (10) step();
    chk("set_frozen", 32'({sec_t, sec_u}), 32'(0));
    tick_cnt = 0;
    repeat (3) key_press(1);
    key_press(10);
    chk("set_min_04", 32'({min_t, min_u}), 32'(4));
    chk("set_no_carry", 32'(tick_cnt), 32'(0));

    // 6. minute-digit blinking while in SET
    step();
    last_mt = hex_mt;
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef BLINK_EN
      chk("blink_alt", 32'(hex_mt != last_mt), 32'(1));
`else
      chk("mt_steady", 32'(hex_mt), 32'(7'h40));
`endif
      last_mt = hex_mt;
    end

    // 4. hour carry from 59:00
    presses = (59 - m_secs / 60 + 60) % 60;
    for (int i = 0; i < presses; i++) key_press(1);
    chk("min_59", 32'({min_t, min_u}), 32'({3'd5, 4'd9}));
    SW17 = 1'b0;
    tick_cnt = 0;
    repeat (480) step();
    chk("carry_count", 32'(tick_cnt), 32'(1));

    // 5. manual wrap in SET gives no carry; key ignored in RUN
    SW17 = 1'b1;
    step();
    presses = (59 - m_secs / 60 + 60) % 60;
    for (int i = 0; i < presses; i++) key_press(1);
    tick_cnt = 0;
    key_press(1);
    chk("set_wrap_00", 32'({min_t, min_u}), 32'(0));
    chk("set_wrap_no_carry", 32'(tick_cnt), 32'(0));
    SW17 = 1'b0;
    step();
    mins = (min_t * 10) + min_u;
    repeat (3) key_press(1);
    chk("run_key_ignored", 32'((min_t * 10) + min_u), 32'(mins));

    // SW17 rise on the tick edge drops the tick
    for (int i = 0; i < 2 * TD && m_pre != TD - 1; i++) step();
    chk("reached_tick", 32'(m_pre), 32'(TD - 1));
    SW17 = 1'b1;
    step();
    chk("tick_discarded", 32'({sec_t, sec_u}), 32'(0));

    // key edge coinciding with SET -> RUN is dropped
    repeat (3) step();
    mins = (min_t * 10) + min_u;
    KEY_MIN = 1'b1;
    step();
    step();
    SW17 = 1'b0;
    step();
    KEY_MIN = 1'b0;
    step();
    chk("exit_key_dropped", 32'((min_t * 10) + min_u), 32'(mins));

    // random mode/key traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) SW17 = ~SW17;
      KEY_MIN = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
